// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for pipe_stage_chain: upstream valid/ready/data, downstream
// valid/ready/data, flush and the exported occupancy count.
interface pipe_stage_chain_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             flush;
   logic [CW-1:0]    count;

   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic register chain of DEPTH stages with per-stage valid, bubble collapse,
// synchronous flush and a registered occupancy counter.
module pipe_stage_chain #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic              clk,
   input logic              rst,
   pipe_stage_chain_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] vld_p;
   logic [WIDTH-1:0] dat_p [DEPTH];
   logic [DEPTH-1:0] adv;
   logic [CW-1:0]    cnt;
   logic             in_xfer;
   logic             out_xfer;

   // A stage may advance when any stage at or ahead of it is empty, or the sink drains.
   always_comb begin
      logic a;
      adv = '0;
      for (int k = 0; k < DEPTH; k++) begin
         a = bus.out_ready;
         for (int j = k; j < DEPTH; j++) a = a | ~vld_p[j];
         adv[k] = a;
      end
   end

   assign bus.in_ready  = adv[0] & ~bus.flush & rst;
   assign bus.out_valid = vld_p[DEPTH-1] & ~bus.flush;
   assign bus.out_data  = dat_p[DEPTH-1];
   assign bus.count     = cnt;

   assign in_xfer  = bus.in_valid & bus.in_ready;
   assign out_xfer = bus.out_valid & bus.out_ready;

   // Stage valids and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p <= '0;
         cnt   <= '0;
      end else if (bus.flush) begin
         vld_p <= '0;
         cnt   <= '0;
      end else begin
         if (adv[0]) vld_p[0] <= bus.in_valid;
         for (int k = 1; k < DEPTH; k++) begin
            if (adv[k]) vld_p[k] <= vld_p[k-1];
         end
         cnt <= cnt + CW'(in_xfer) - CW'(out_xfer);
      end
   end

   // Stage payloads: written only from a valid source so bubbles leave them quiet
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) dat_p[k] <= RESET_VAL;
      end else if (!bus.flush) begin
         if (adv[0] && bus.in_valid) dat_p[0] <= bus.in_data;
         for (int k = 1; k < DEPTH; k++) begin
            if (adv[k] && vld_p[k-1]) dat_p[k] <= dat_p[k-1];
         end
      end
   end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: a DEPTH=4 and a DEPTH=1 instance, each
// tracked by an entry/position model and an in-order output scoreboard.
module tb_pipe_stage_chain;
   localparam int          W4  = 32;
   localparam int          D4  = 4;
   localparam int          W1  = 8;
   localparam int          D1  = 1;
   localparam logic [31:0] RV4 = 32'hDEAD_BEEF;
   localparam logic [7:0]  RV1 = 8'h5A;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_stage_chain_if #(.WIDTH(W4), .DEPTH(D4)) bus4();
   pipe_stage_chain_if #(.WIDTH(W1), .DEPTH(D1)) bus1();

   pipe_stage_chain #(.WIDTH(W4), .DEPTH(D4), .RESET_VAL(RV4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   pipe_stage_chain #(.WIDTH(W1), .DEPTH(D1), .RESET_VAL(RV1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int   tests = 0;
   int   fails = 0;
   bit   done  = 1'b0;
   bit   done1 = 1'b0;

   logic [31:0] sb4 [$];
   logic [7:0]  sb1 [$];
   logic [31:0] m4_d [$];
   int          m4_p [$];
   bit          m1_full = 1'b0;
   logic [7:0]  m1_d;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [63:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got %0h with nothing expected", name, act);
   endtask

   task automatic step4(input logic v, input logic [31:0] d, input logic ordy, input logic fl,
                        output bit acc, output bit ov);
      bus4.in_valid  = v;
      bus4.in_data   = d;
      bus4.out_ready = ordy;
      bus4.flush     = fl;
      @(negedge clk);
      acc = v && bus4.in_ready;
      ov  = bus4.out_valid;
      @(posedge clk);
      #1;
   endtask

   task automatic step1(input logic v, input logic [7:0] d, input logic ordy, input logic fl,
                        output bit acc, output bit ov);
      bus1.in_valid  = v;
      bus1.in_data   = d;
      bus1.out_ready = ordy;
      bus1.flush     = fl;
      @(negedge clk);
      acc = v && bus1.in_ready;
      ov  = bus1.out_valid;
      @(posedge clk);
      #1;
   endtask

   // Reference for DEPTH=4: entries in order, each with its stage index
   always @(negedge clk) begin
      if (!rst) begin
         chk("d4_rst_in_ready", bus4.in_ready, 0);
         chk("d4_rst_out_valid", bus4.out_valid, 0);
         chk("d4_rst_count", bus4.count, 0);
         chk("d4_rst_out_data", bus4.out_data, RV4);
         m4_d.delete(); m4_p.delete(); sb4.delete();
      end else begin
         bit ir, ovx;
         int n;
         n   = m4_d.size();
         ir  = !bus4.flush && (n < D4 || bus4.out_ready);
         ovx = !bus4.flush && n > 0 && m4_p[0] == D4 - 1;
         chk("d4_in_ready", bus4.in_ready, ir);
         chk("d4_out_valid", bus4.out_valid, ovx);
         chk("d4_count", bus4.count, n);
         if (ovx) chk("d4_out_data", bus4.out_data, m4_d[0]);
         if (bus4.flush) begin
            m4_d.delete(); m4_p.delete(); sb4.delete();
         end else begin
            if (ovx && bus4.out_ready) begin
               void'(m4_d.pop_front());
               void'(m4_p.pop_front());
            end
            for (int i = 0; i < m4_p.size(); i++)
               if (bus4.out_ready || i < D4 - 1 - m4_p[i]) m4_p[i]++;
            if (bus4.in_valid && ir) begin
               m4_d.push_back(bus4.in_data);
               m4_p.push_back(0);
               sb4.push_back(bus4.in_data);
            end
         end
      end
   end

   // Reference for DEPTH=1: one slot
   always @(negedge clk) begin
      if (!rst) begin
         chk("d1_rst_in_ready", bus1.in_ready, 0);
         chk("d1_rst_out_valid", bus1.out_valid, 0);
         chk("d1_rst_count", bus1.count, 0);
         chk("d1_rst_out_data", bus1.out_data, RV1);
         m1_full = 1'b0;
         sb1.delete();
      end else begin
         bit ir, ovx;
         ir  = !bus1.flush && (!m1_full || bus1.out_ready);
         ovx = !bus1.flush && m1_full;
         chk("d1_in_ready", bus1.in_ready, ir);
         chk("d1_out_valid", bus1.out_valid, ovx);
         chk("d1_count", bus1.count, m1_full);
         if (ovx) chk("d1_out_data", bus1.out_data, m1_d);
         if (bus1.flush) begin
            m1_full = 1'b0;
            sb1.delete();
         end else begin
            if (ovx && bus1.out_ready) m1_full = 1'b0;
            if (bus1.in_valid && ir) begin
               m1_full = 1'b1;
               m1_d    = bus1.in_data;
               sb1.push_back(bus1.in_data);
            end
         end
      end
   end

   // Output monitors
   always @(negedge clk) begin
      if (rst && bus4.out_valid && bus4.out_ready) begin
         if (sb4.size() == 0) fail_now("d4_sb_empty", bus4.out_data);
         else chk("d4_out_order", bus4.out_data, sb4.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst && bus1.out_valid && bus1.out_ready) begin
         if (sb1.size() == 0) fail_now("d1_sb_empty", bus1.out_data);
         else chk("d1_out_order", bus1.out_data, sb1.pop_front());
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // DEPTH=1 stimulus
   initial begin
      bit acc, ov;
      int first;
      logic [7:0] v1 [3];
      v1 = '{8'h11, 8'h22, 8'h33};
      bus1.in_valid = 0; bus1.in_data = '0; bus1.out_ready = 0; bus1.flush = 0;
      @(posedge rst);
      first = -1;
      for (int c = 0; c < 6; c++) begin
         step1(c < 3, (c < 3) ? v1[c] : 8'h00, 1'b1, 1'b0, acc, ov);
         if (ov && first < 0) first = c;
      end
      chk("d1_latency", first, D1);
      while (!done)
         step1($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 60,
               $urandom_range(0, 99) < 5, acc, ov);
      repeat (3) step1(1'b0, 8'h00, 1'b1, 1'b0, acc, ov);
      done1 = 1'b1;
   end

   // DEPTH=4 stimulus
   initial begin
      bit acc, ov;
      int k, first;
      logic [31:0] vals [6];
      vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
      bus4.in_valid = 0; bus4.in_data = '0; bus4.out_ready = 0; bus4.flush = 0;
      #2 rst = 1'b0;
      #1;
      chk("d4_reset_out_data", bus4.out_data, RV4);
      chk("d4_reset_in_ready", bus4.in_ready, 0);
      chk("d1_reset_out_data", bus1.out_data, RV1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;

      first = -1;
      for (int c = 0; c < 10; c++) begin
         step4(c < 3, (c < 3) ? vals[c] : 32'h0, 1'b1, 1'b0, acc, ov);
         if (ov && first < 0) first = c;
      end
      chk("d4_latency", first, D4);

      k = 0;
      for (int c = 0; c < 8; c++) begin
         step4(1'b1, vals[k], 1'b0, 1'b0, acc, ov);
         if (acc) k++;
      end
      chk("d4_stall_accepts", k, 4);
      chk("d4_stall_count", bus4.count, 4);
      chk("d4_stall_head", bus4.out_data, 32'h11);
      for (int c = 0; c < 12; c++) begin
         step4(k < 6, (k < 6) ? vals[k] : 32'h0, 1'b1, 1'b0, acc, ov);
         if (acc) k++;
      end
      chk("d4_drain_accepts", k, 6);

      step4(1'b1, 32'hA0, 1'b0, 1'b0, acc, ov);
      repeat (2) step4(1'b0, 32'h0, 1'b0, 1'b0, acc, ov);
      step4(1'b1, 32'hA1, 1'b0, 1'b0, acc, ov);
      repeat (3) step4(1'b0, 32'h0, 1'b0, 1'b0, acc, ov);
      chk("d4_bubble_count", bus4.count, 2);
      chk("d4_bubble_head", bus4.out_data, 32'hA0);
      step4(1'b0, 32'h0, 1'b1, 1'b0, acc, ov);
      chk("d4_bubble_out0", ov, 1);
      step4(1'b0, 32'h0, 1'b1, 1'b0, acc, ov);
      chk("d4_bubble_out1", ov, 1);
      repeat (3) step4(1'b0, 32'h0, 1'b1, 1'b0, acc, ov);

      for (int c = 0; c < 3; c++) step4(1'b1, 32'hF0 + c, 1'b0, 1'b0, acc, ov);
      chk("d4_preflush_count", bus4.count, 3);
      step4(1'b1, 32'h77, 1'b1, 1'b1, acc, ov);
      chk("d4_flush_no_accept", acc, 0);
      chk("d4_flush_no_out", ov, 0);
      bus4.flush = 0; bus4.in_valid = 0;
      #1;
      chk("d4_postflush_count", bus4.count, 0);
      chk("d4_postflush_out_valid", bus4.out_valid, 0);
      chk("d4_postflush_in_ready", bus4.in_ready, 1);

      for (int c = 0; c < 4; c++) step4(1'b1, 32'hC0 + c, 1'b0, 1'b0, acc, ov);
      chk("d4_full_count", bus4.count, 4);
      step4(1'b1, 32'hC4, 1'b1, 1'b0, acc, ov);
      chk("d4_both_accept", acc, 1);
      chk("d4_both_count", bus4.count, 4);
      repeat (8) step4(1'b0, 32'h0, 1'b1, 1'b0, acc, ov);

      for (int c = 0; c < 1500; c++)
         step4($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 70,
               $urandom_range(0, 99) < 5, acc, ov);

      repeat (6) step4(1'b0, 32'h0, 1'b1, 1'b0, acc, ov);
      step4(1'b1, 32'hE1, 1'b0, 1'b0, acc, ov);
      step4(1'b1, 32'hE2, 1'b0, 1'b0, acc, ov);
      bus4.in_valid = 0;
      chk("d4_prereset_count", bus4.count, 2);
      #2 rst = 1'b0;
      #1;
      chk("d4_async_out_valid", bus4.out_valid, 0);
      chk("d4_async_count", bus4.count, 0);
      chk("d4_async_out_data", bus4.out_data, RV4);
      @(posedge clk);
      #1 rst = 1'b1;

      repeat (6) step4(1'b0, 32'h0, 1'b1, 1'b0, acc, ov);
      chk("d4_sb_drained", sb4.size(), 0);
      done = 1'b1;
      for (int i = 0; i < 50 && !done1; i++) @(posedge clk);
      chk("d1_driver_done", done1, 1);
      chk("d1_sb_drained", sb1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised elastic pipeline register chain that replaces the fixed, hand-written inter-stage registers of the pipelined MIPS (F->D, D->E, E->M, M->W) with one generic block. It carries a WIDTH-bit payload through DEPTH stages. Each stage has a valid bit and a valid/ready handshake, so the chain supports:
- stall by backpressure,
- bubble collapse (a full stage advances into an empty stage ahead of it),
- a synchronous flush that squashes every in-flight entry (branch taken).

An occupancy counter is exported for hazard and debug logic.

## Interface
Parameters:
- WIDTH, 32: payload width in bits (>= 1)
- DEPTH, 4: number of register stages (>= 1)
- RESET_VAL, 0: value loaded into every stage payload register on reset

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low; rst=0 clears the chain immediately
- in_valid  in  1  upstream offers in_data
- in_data  in  WIDTH  payload entering stage 0
- in_ready  out  1  stage 0 accepts this cycle; a transfer occurs when in_valid && in_ready at the edge
- out_valid  out  1  stage DEPTH-1 holds a valid entry
- out_data  out  WIDTH  payload of stage DEPTH-1
- out_ready  in  1  downstream consumes; a transfer occurs when out_valid && out_ready at the edge
- flush  in  1  squash all entries at the next edge
- count  out  $clog2(DEPTH+1)  number of valid stages, registered

## Operation
- State per stage k (0 = input end, DEPTH-1 = output end): v[k] and d[k].
- Advance terms:
  - adv[DEPTH-1] = !v[DEPTH-1] || out_ready
  - adv[k] = !v[k] || adv[k+1] for k < DEPTH-1. This is the bubble collapse: an empty stage always accepts.
- Outputs:
  - in_ready = adv[0] && !flush && rst
  - out_valid = v[DEPTH-1] && !flush
  - out_data = d[DEPTH-1]
- Edge update when flush=0:
  - If adv[k], stage k loads from stage k-1: v[k] <= v[k-1] and d[k] <= d[k-1].
  - For k=0 the source is the input: v[0] <= in_valid, d[0] <= in_data.
  - If !adv[k], stage k holds.
  - d[k] is written only when its source is valid. An invalid source loads v only, so payload registers do not toggle on bubbles.
- Flush: at the edge all v[k] <= 0 and count <= 0. d[k] is unchanged.
  - While flush=1, no input or output transfer takes place, because in_ready and out_valid are both forced 0.
  - flush overrides all advance terms.
- count:
  - count <= count + (in transfer) - (out transfer); both may happen in the same cycle (net 0).
  - count is always equal to the number of set v[k].
  - count never exceeds DEPTH. It is 0 whenever out_valid=0 and no stage is valid.
- Stability rule: while out_valid && !out_ready, out_data and out_valid hold until the transfer completes or a flush occurs.
- DEPTH=1: the block is a single register slot. in_ready = !v[0] || out_ready.
- The in_ready path from out_ready is combinational, through up to DEPTH OR gates. No register-to-register ready path is required.

## Timing
- Reset (asynchronous, rst=0): all v=0, all d=RESET_VAL, count=0, out_valid=0, out_data=RESET_VAL, in_ready=0.
- First edge after rst returns to 1: in_ready=1 (chain empty, flush=0).
- Latency: an entry accepted at edge N on an empty chain shows out_valid=1 after edge N+DEPTH-1, when its value is visible in stage DEPTH-1. That is DEPTH cycles from the in_valid cycle to the out_data cycle.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Full chain with out_ready=0: in_ready=0 in the same cycle. It rises combinationally in the cycle out_ready rises.
- Partial stall: with out_ready=0, upstream entries keep advancing into empty stages until the chain is full. At that point count=DEPTH.
- Flush takes effect at the next edge. The following cycle shows count=0, out_valid=0 and in_ready=1.
- Reset asserted mid-operation: the chain is cleared without waiting for clk. Any partially completed handshake is lost.

## Test plan
- Reset, then WIDTH=32/DEPTH=4 fed 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_valid first high 4 cycles after 0x11 is offered; outputs 0x11,0x22,0x33 on back-to-back cycles; count peaks at 3 and returns to 0.
- out_ready=0 while feeding 6 entries -> in_ready drops after the 4th accept; count=4; out_data stays 0x11 stable. Raise out_ready -> entries drain in order and in_ready=1 in the same cycle.
- Bubble collapse: accept 0xA0, idle 2 cycles, accept 0xA1, with out_ready=0 -> after 4 edges count=2 and the entries sit in stages 3 and 2 with no bubble between them.
- Flush with count=3 and in_valid=1 at the same edge -> count=0 next cycle; the input is not accepted; no out transfer occurs that cycle; out_valid=0.
- Simultaneous in and out transfer at count=4 with out_ready=1 -> count stays 4; order is preserved.
- rst pulled low between clock edges with count=2 -> out_valid=0, count=0 and out_data=RESET_VAL immediately, before the next edge; DEPTH=1 variant repeats the first scenario with a latency of 1.
